// File: rtl/voice_scheduler_if.sv
// Configuration write port and time-multiplexed phase output bundle of the voice scheduler.
// The master side configures voices and consumes outputs; the slave side is the scheduler.
interface voice_scheduler_if #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic               cfg_wr;
    logic [VW-1:0]      cfg_voice;
    logic [PHASE_W-1:0] cfg_freq;
    logic [7:0]         cfg_duty;
    logic               cfg_enable;
    logic               cfg_ready;
    logic               phase_valid;
    logic [VW-1:0]      phase_voice;
    logic [PHASE_W-1:0] phase_out;
    logic               square_out;
    logic               frame_start;

    modport master (
        output cfg_wr, cfg_voice, cfg_freq, cfg_duty, cfg_enable,
        input  cfg_ready, phase_valid, phase_voice, phase_out, square_out, frame_start
    );

    modport slave (
        input  cfg_wr, cfg_voice, cfg_freq, cfg_duty, cfg_enable,
        output cfg_ready, phase_valid, phase_voice, phase_out, square_out, frame_start
    );
endinterface

// File: rtl/voice_scheduler.sv
// Time-multiplexed phase accumulator: one shared adder serves NUM_VOICES voices in
// round-robin slots, producing a registered phase word and PWM bit per slot.
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    voice_scheduler_if.slave bus
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [VW-1:0]         slot_reg;
    logic [PHASE_W-1:0]    phase_arr [NUM_VOICES];
    logic [PHASE_W-1:0]    freq_arr  [NUM_VOICES];
    logic [7:0]            duty_arr  [NUM_VOICES];
    logic [NUM_VOICES-1:0] enable_vec;

    logic                  cfg_accept;
    logic                  slot_enable;
    logic [PHASE_W-1:0]    sum_phase;
    logic [PHASE_W-1:0]    phase_next;

    logic                  phase_valid_reg;
    logic [VW-1:0]         phase_voice_reg;
    logic [PHASE_W-1:0]    phase_out_reg;
    logic                  square_out_reg;
    logic                  frame_start_reg;

    // Blocking writes to the voice being computed keeps config and phase update disjoint.
    assign bus.cfg_ready = rst_n && (bus.cfg_voice != slot_reg);
    assign cfg_accept    = bus.cfg_wr && bus.cfg_ready;

    assign slot_enable = enable_vec[slot_reg];
    assign sum_phase   = phase_arr[slot_reg] + freq_arr[slot_reg];
    assign phase_next  = slot_enable ? sum_phase : phase_arr[slot_reg];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [PHASE_W-1:0] phase_reg;
            logic [PHASE_W-1:0] freq_reg;
            logic [7:0]         duty_reg;
            logic               enable_reg;
            logic               cfg_hit;

            assign cfg_hit = cfg_accept && (bus.cfg_voice == VW'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    phase_reg  <= '0;
                    freq_reg   <= '0;
                    duty_reg   <= 8'h80;
                    enable_reg <= 1'b0;
                end else begin
                    if (slot_reg == VW'(gi)) begin
                        phase_reg <= phase_next;
                    end
                    if (cfg_hit) begin
                        freq_reg   <= bus.cfg_freq;
                        duty_reg   <= bus.cfg_duty;
                        enable_reg <= bus.cfg_enable;
                        // Disabling restarts the voice from zero; retuning an enabled voice keeps phase.
                        if (!bus.cfg_enable) begin
                            phase_reg <= '0;
                        end
                    end
                end
            end

            assign phase_arr[gi]  = phase_reg;
            assign freq_arr[gi]   = freq_reg;
            assign duty_arr[gi]   = duty_reg;
            assign enable_vec[gi] = enable_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_reg        <= '0;
            phase_valid_reg <= 1'b0;
            phase_voice_reg <= '0;
            phase_out_reg   <= '0;
            square_out_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            slot_reg        <= slot_reg + VW'(1);
            phase_valid_reg <= slot_enable;
            phase_voice_reg <= slot_reg;
            phase_out_reg   <= phase_next;
            square_out_reg  <= slot_enable && (phase_next[PHASE_W-1 -: 8] < duty_arr[slot_reg]);
            frame_start_reg <= (slot_reg == '0);
        end
    end

    assign bus.phase_valid = phase_valid_reg;
    assign bus.phase_voice = phase_voice_reg;
    assign bus.phase_out   = phase_out_reg;
    assign bus.square_out  = square_out_reg;
    assign bus.frame_start = frame_start_reg;
endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: per-voice arithmetic reference model
// driven alongside directed and randomized configuration traffic.
module tb_voice_scheduler;
    localparam int NV = 4;
    localparam int PW = 24;
    localparam int unsigned PMASK = 32'h00FF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    voice_scheduler_if #(.NUM_VOICES(NV), .PHASE_W(PW)) bus ();

    voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: per-voice settings and phase, plus the slot served at the next edge.
    int unsigned m_freq  [NV];
    int unsigned m_phase [NV];
    int unsigned m_duty  [NV];
    bit          m_en    [NV];
    int          m_slot;

    bit          exp_valid;
    int          exp_voice;
    int unsigned exp_phase;
    bit          exp_square;
    bit          exp_frame;
    bit          acc;

    function automatic logic [28:0] obs_vec();
        return {bus.phase_valid, bus.phase_voice, bus.phase_out,
                bus.square_out & bus.phase_valid, bus.frame_start};
    endfunction

    function automatic logic [28:0] exp_vec();
        logic [23:0] p;
        p = exp_phase[23:0];
        return {exp_valid, 2'(exp_voice), p, exp_square & exp_valid, exp_frame};
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_freq[v] = 0; m_phase[v] = 0; m_duty[v] = 32'h80; m_en[v] = 1'b0;
        end
        m_slot = 0;
        exp_valid = 0; exp_voice = 0; exp_phase = 0; exp_square = 0; exp_frame = 0;
    endtask

    // Advance one clock edge, update the model from the stimulus present at that edge,
    // then move to the sampling point 1 time unit later.
    task automatic tick();
        int s;
        int unsigned nw;
        @(posedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            s  = m_slot;
            nw = m_en[s] ? ((m_phase[s] + m_freq[s]) & PMASK) : m_phase[s];
            exp_valid  = m_en[s];
            exp_voice  = s;
            exp_phase  = nw;
            exp_square = m_en[s] && ((nw >> 16) < m_duty[s]);
            exp_frame  = (s == 0);
            m_phase[s] = nw;
            if (bus.cfg_wr && (int'(bus.cfg_voice) != s)) begin
                acc = 1'b1;
                m_freq[bus.cfg_voice] = int'(bus.cfg_freq);
                m_duty[bus.cfg_voice] = int'(bus.cfg_duty);
                m_en[bus.cfg_voice]   = bus.cfg_enable;
                if (!bus.cfg_enable) m_phase[bus.cfg_voice] = 0;
            end
            m_slot = (s + 1) % NV;
        end
        #1;
    endtask

    task automatic cfg_write(input int v, input int unsigned f, input int unsigned d, input bit en);
        bit done;
        done = 1'b0;
        bus.cfg_wr = 1'b1; bus.cfg_voice = 2'(v); bus.cfg_freq = 24'(f);
        bus.cfg_duty = 8'(d); bus.cfg_enable = en;
        for (int i = 0; i < 4 && !done; i++) begin
            tick();
            done = acc;
        end
        bus.cfg_wr = 1'b0;
        if (done) $display("cfg write voice=%0d freq=%06h duty=%02h en=%0d", v, f, d, en);
        else begin
            checks++;
            $display("FAIL cfg_write_timeout voice=%0d not accepted within 4 cycles", v);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; bus.cfg_wr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_voice = 2'd1;
        tick(); tick();
        checks++;
        if (bus.cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready got %b want 0", bus.cfg_ready);
        else passes++;
        checks++;
        if (obs_vec() !== 29'd0) $display("FAIL reset_outputs got %h want 0", obs_vec());
        else passes++;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.frame_start !== (i % 4 == 0) || bus.phase_valid !== 1'b0 || bus.phase_out !== 24'd0)
                $display("FAIL idle_cycle%0d got frame=%b valid=%b phase=%h want frame=%b valid=0 phase=0",
                         i, bus.frame_start, bus.phase_valid, bus.phase_out, (i % 4 == 0));
            else passes++;
        end
    endtask

    task automatic test_single_voice();
        int unsigned seen[$];
        cfg_write(1, 32'h000100, 32'h80, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL single_voice cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            else passes++;
            if (bus.phase_valid && bus.phase_voice == 2'd1) seen.push_back(int'(bus.phase_out));
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seen.size() <= k || seen[k] != 32'h100 * (k + 1))
                $display("FAIL voice1_phase%0d got %h want %h", k, (seen.size() > k) ? seen[k] : 0, 32'h100 * (k + 1));
            else passes++;
        end
    endtask

    task automatic test_wrap();
        int unsigned seen[$];
        cfg_write(2, 32'hFFFFFF, 32'h80, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL wrap cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            else passes++;
            if (bus.phase_valid && bus.phase_voice == 2'd2) seen.push_back(int'(bus.phase_out));
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seen.size() <= k || seen[k] != (32'h1000000 - (k + 1)))
                $display("FAIL voice2_wrap%0d got %h want %h", k, (seen.size() > k) ? seen[k] : 0, 32'h1000000 - (k + 1));
            else passes++;
        end
    endtask

    task automatic test_ready_conflict();
        int v;
        v = m_slot;
        bus.cfg_wr = 1'b1; bus.cfg_voice = 2'(v); bus.cfg_freq = 24'h000010;
        bus.cfg_duty = 8'h20; bus.cfg_enable = 1'b1;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b0) $display("FAIL ready_conflict got %b want 0", bus.cfg_ready);
        else passes++;
        tick();
        checks++;
        if (bus.cfg_ready !== 1'b1) $display("FAIL ready_next_cycle got %b want 1", bus.cfg_ready);
        else passes++;
        tick();
        bus.cfg_wr = 1'b0;
        $display("cfg write voice=%0d freq=000010 duty=20 en=1 (after conflict)", v);
        for (int i = 0; i < 2 * NV; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL conflict_effect cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_duty();
        int unsigned duties[5] = '{32'h00, 32'h40, 32'h80, 32'hC0, 32'hFF};
        int pct[5] = '{0, 25, 50, 75, 100};
        apply_reset();
        for (int d = 0; d < 5; d++) begin
            int vcnt, high, want;
            vcnt = 0; high = 0;
            cfg_write(0, 32'h100000, duties[d], 1'b1);
            for (int c = 0; c < 5000 && vcnt < 1024; c++) begin
                tick();
                checks++;
                if (obs_vec() !== exp_vec()) $display("FAIL duty%02h cyc%0d got %h want %h", duties[d], c, obs_vec(), exp_vec());
                else passes++;
                if (bus.phase_valid && bus.phase_voice == 2'd0) begin
                    vcnt++;
                    high += int'(bus.square_out);
                end
            end
            want = pct[d] * 1024 / 100;
            checks++;
            if (vcnt != 1024 || high - want > 20 || want - high > 20)
                $display("FAIL duty%02h_fraction got %0d/%0d high want %0d/1024 +-20", duties[d], high, vcnt, want);
            else passes++;
        end
    endtask

    task automatic test_freq();
        int upd[NV], wraps[NV];
        int unsigned prev[NV];
        bit found;
        apply_reset();
        for (int v = 0; v < NV; v++) begin
            upd[v] = 0; wraps[v] = 0; prev[v] = 0;
            cfg_write(v, 32'h024000, 32'h80, 1'b1);
        end
        for (int c = 0; c < 20000; c++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL freq cyc%0d got %h want %h", c, obs_vec(), exp_vec());
            else passes++;
            if (bus.phase_valid) begin
                upd[bus.phase_voice]++;
                if (int'(bus.phase_out) < prev[bus.phase_voice]) wraps[bus.phase_voice]++;
                prev[bus.phase_voice] = int'(bus.phase_out);
            end
        end
        for (int v = 0; v < NV; v++) begin
            longint want;
            want = (longint'(upd[v]) * 64'h24000) >> 24;
            checks++;
            if (upd[v] < 4990 || longint'(wraps[v]) - want > 1 || want - longint'(wraps[v]) > 1)
                $display("FAIL voice%0d_wraps got %0d over %0d updates want %0d", v, wraps[v], upd[v], want);
            else passes++;
        end
        cfg_write(3, 32'h024000, 32'h80, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (bus.phase_voice == 2'd3) begin
                found = 1'b1;
                checks++;
                if (bus.phase_out !== 24'd0 || bus.phase_valid !== 1'b0)
                    $display("FAIL disable_clears got phase=%h valid=%b want 0/0", bus.phase_out, bus.phase_valid);
                else passes++;
            end
        end
        if (!found) begin
            checks++;
            $display("FAIL disable_clears_timeout voice 3 slot not seen");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (!bus.cfg_wr && $urandom_range(0, 2) == 0) begin
                bus.cfg_wr = 1'b1;
                bus.cfg_voice = 2'($urandom_range(0, NV - 1));
                bus.cfg_freq = 24'($urandom);
                bus.cfg_duty = 8'($urandom);
                bus.cfg_enable = ($urandom_range(0, 3) != 0);
            end
            #1;
            checks++;
            if (bus.cfg_ready !== (int'(bus.cfg_voice) != m_slot))
                $display("FAIL rand_ready it%0d got %b want %b", i, bus.cfg_ready, (int'(bus.cfg_voice) != m_slot));
            else passes++;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL rand_out it%0d got %h want %h", i, obs_vec(), exp_vec());
            else passes++;
            if (acc) begin
                $display("cfg write voice=%0d freq=%06h duty=%02h en=%0d",
                         bus.cfg_voice, bus.cfg_freq, bus.cfg_duty, bus.cfg_enable);
                bus.cfg_wr = 1'b0;
            end
        end
        bus.cfg_wr = 1'b0;
    endtask

    task automatic test_midreset();
        bus.cfg_wr = 1'b1; bus.cfg_voice = 2'((m_slot + 1) % NV);
        bus.cfg_freq = 24'h001000; bus.cfg_duty = 8'h80; bus.cfg_enable = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b0) $display("FAIL midreset_ready got %b want 0", bus.cfg_ready);
        else passes++;
        tick();
        checks++;
        if (obs_vec() !== 29'd0) $display("FAIL midreset_outputs got %h want 0", obs_vec());
        else passes++;
        bus.cfg_wr = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec() || bus.phase_valid !== 1'b0)
                $display("FAIL midreset_after cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            else passes++;
        end
    endtask

    initial begin
        bus.cfg_wr = 1'b0; bus.cfg_voice = '0; bus.cfg_freq = '0;
        bus.cfg_duty = '0; bus.cfg_enable = 1'b0;
        model_reset();
        test_reset();
        test_single_voice();
        test_wrap();
        test_ready_conflict();
        test_random();
        test_midreset();
        test_duty();
        test_freq();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
